data_mem_stage: RTL

- MEM stage of the 5-stage pipeline CPU, directly downstream of the EX/MEM register.
- Takes the ALU result as the address and the rt value as store data.
- Performs word, halfword and byte loads and stores on a local data RAM with parameterisable access latency.
- Raises a stall to the hazard unit while an access is in flight. The hazard unit holds EX/MEM (exe_mem_write=0) and the upstream stages while stall is high.

---
 rtl/data_mem_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_mem_stage.sv
// MEM stage: word/halfword/byte loads and stores on a local data RAM whose
// accesses take LATENCY cycles, stalling the pipeline while one is in flight.
module data_mem_stage #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic [31:0] rdata_out,
   output logic        stall_out,
   output logic        addr_err_out
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;
   localparam bit          SINGLE   = (LATENCY == 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               stall_c, done_c;

   logic [31:0]        mem [DEPTH];
   logic [AW-1:0]      idx;
   logic [31:0]        rword;
   logic               req, is_half, is_byte, misaligned, access;
   logic [3:0]         be;
   logic [31:0]        wd;
   logic [31:0]        byte_shift;
   logic [15:0]        half_sel;
   logic [31:0]        load_val;
   logic               write_en;
   logic               unused_addr;

   assign unused_addr = ^addr_in[31:AW+2];

   assign req        = valid_in & (mem_read_in | mem_write_in);
   assign is_half    = (size_in == 2'b01);
   assign is_byte    = (size_in == 2'b10);
   assign misaligned = is_half ? addr_in[0] : (is_byte ? 1'b0 : (|addr_in[1:0]));
   assign access     = req & ~misaligned;
   assign idx        = addr_in[AW+1:2];
   assign rword      = mem[idx];

   // State and latency counter; reset abandons any access in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (SINGLE) begin
                  done_c = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  state_d = BUSY;
                  cnt_d   = CNT_W'(CNT_LOAD);
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               stall_c = 1'b1;
               cnt_d   = cnt_q - CNT_W'(1);
            end else begin
               // Completion uses whatever request is presented now.
               done_c  = access;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Store lane enables and replicated write data.
   always_comb begin
      be = 4'b1111;
      wd = wdata_in;
      if (is_half) begin
         be = addr_in[1] ? 4'b1100 : 4'b0011;
         wd = {2{wdata_in[15:0]}};
      end else if (is_byte) begin
         be = 4'b0001 << addr_in[1:0];
         wd = {4{wdata_in[7:0]}};
      end
   end

   assign write_en = reset & done_c & mem_write_in;

   always_ff @(posedge clock) begin
      if (write_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   // Little-endian lane select with sign or zero extension.
   assign byte_shift = rword >> {addr_in[1:0], 3'b000};
   assign half_sel   = addr_in[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      load_val = rword;
      if (is_half) begin
         load_val = {{16{~unsigned_in & half_sel[15]}}, half_sel};
      end else if (is_byte) begin
         load_val = {{24{~unsigned_in & byte_shift[7]}}, byte_shift[7:0]};
      end
   end

   assign rdata_out    = (reset & done_c & ~mem_write_in) ? load_val : 32'h0;
   assign stall_out    = reset & stall_c;
   assign addr_err_out = reset & req & misaligned;

endmodule
